// File: rtl/bram_burst_reader_if.sv
// ---------------------------------------------------------------------------
// bram_burst_reader_if
//   Output stream bundle of the BRAM burst reader.
//   m_data  : beat payload
//   m_valid : source has a beat
//   m_ready : sink accepts the beat this cycle
//   m_last  : final beat of the burst
//   master  : driven by the reader; slave : driven by the sink.
// ---------------------------------------------------------------------------
interface bram_burst_reader_if #(
  parameter int RAM_WIDTH = 18
);
  logic [RAM_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (output m_data, output m_valid, output m_last, input  m_ready);
  modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);
endinterface

// File: rtl/bram_burst_reader.sv
// ---------------------------------------------------------------------------
// bram_burst_reader
//   Reads a burst of consecutive words from a dual-port block RAM and streams
//   them out with valid/ready flow control. The read address wraps at the top
//   of the RAM. Reads are only issued when the skid FIFO is guaranteed room
//   for every word still in the RAM pipeline, so back-pressure never loses data.
//
//   clka        : single clock for the block and the RAM
//   rstb        : synchronous, active-high reset
//   start       : one-cycle burst request (ignored while busy)
//   start_addr  : first word address
//   length      : word count, 0 .. 2^ADDR_WIDTH
//   busy        : burst in progress
//   done        : one-cycle burst-complete pulse
//   ram_*       : RAM read port (ram_dout returns RD_LATENCY cycles after ram_en)
//   m_stream    : output stream (m_data / m_valid / m_ready / m_last)
// ---------------------------------------------------------------------------
module bram_burst_reader #(
  parameter int RAM_WIDTH  = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clka,
  input  logic                    rstb,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     length,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_regce,
  output logic                    ram_rst,
  input  logic [RAM_WIDTH-1:0]    ram_dout,
  bram_burst_reader_if.master     m_stream
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                 state, next_state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       issued_cnt;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   done_q;
  logic                   done_set;
  logic                   accept;

  // Bit i set means a read issued i+1 cycles ago is still in the RAM pipeline.
  logic [RD_LATENCY-1:0]  vpipe;
  logic [CNT_W-1:0]       inflight;

  logic [RAM_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   push, pop;
  logic                   credit_ok;
  logic                   m_valid_c, m_last_c;

  // Reads in flight plus words already buffered must never exceed the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vpipe[i]);
    end
  end

  assign credit_ok = (inflight + fifo_cnt) < CNT_W'(FIFO_DEPTH);
  assign push      = vpipe[RD_LATENCY-1];
  assign m_valid_c = (fifo_cnt != '0);
  assign pop       = m_valid_c && m_stream.m_ready;
  // beat_cnt counts beats already transferred, so the head beat is number beat_cnt+1.
  assign m_last_c  = m_valid_c && ((beat_cnt + LEN_W'(1)) == len_q);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    ram_en     = 1'b0;
    done_set   = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept     = 1'b1;
            next_state = READ;
          end else begin
            done_set   = 1'b1;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          ram_en = 1'b1;
          if ((issued_cnt + LEN_W'(1)) == len_q) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last_c) begin
          done_set   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // No read is launched in a cycle whose closing edge resets the block.
    if (rstb) ram_en = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clka) begin
    if (rstb) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      addr_q     <= '0;
      len_q      <= '0;
      issued_cnt <= '0;
      beat_cnt   <= '0;
      done_q     <= 1'b0;
      vpipe      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      done_q <= done_set;
      vpipe  <= (vpipe << 1) | RD_LATENCY'(ram_en);

      if (accept) begin
        addr_q     <= start_addr;
        len_q      <= length;
        issued_cnt <= '0;
        beat_cnt   <= '0;
      end
      if (ram_en) begin
        addr_q     <= addr_q + ADDR_WIDTH'(1);
        issued_cnt <= issued_cnt + LEN_W'(1);
      end
      if (pop) beat_cnt <= beat_cnt + LEN_W'(1);

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clka) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_we    = 1'b0;
  assign ram_regce = 1'b1;
  assign ram_rst   = rstb;

  assign m_stream.m_data  = fifo_mem[rd_ptr];
  assign m_stream.m_valid = m_valid_c;
  assign m_stream.m_last  = m_last_c;

endmodule
